// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing a single-port RAM between one writer and one reader.
// RAM strobes/addresses are registered; read data returns through a fixed-latency token pipe.
`timescale 1ns/1ps
module ram_access_arbiter #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 12,
    parameter int RD_LATENCY = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0] wr_req_data,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_rsp_valid,
    output logic [DATA_W-1:0] rd_rsp_data,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_wr_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_read,
    output logic [ADDR_W-1:0] ram_rd_address,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic [15:0]       conflict_count
);

    typedef enum logic [1:0] {IDLE, WRITE, READ} phase_e;

    phase_e              phase_q, phase_d;
    logic                last_rd_q, last_rd_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [RD_LATENCY:0] vld_pipe_q, vld_pipe_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [15:0]         conflict_q, conflict_d;
    logic                wr_gnt, rd_gnt;

    // Grant never looks at ram_data_out; held off entirely while reset is asserted.
    always_comb begin
        wr_gnt = resetn && wr_req_valid && (!rd_req_valid || last_rd_q);
        rd_gnt = resetn && rd_req_valid && (!wr_req_valid || !last_rd_q);
    end

    always_comb begin
        phase_d    = IDLE;
        last_rd_d  = last_rd_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_addr_d  = rd_addr_q;
        conflict_d = conflict_q;
        if (wr_gnt) begin
            phase_d   = WRITE;
            last_rd_d = 1'b0;
            wr_addr_d = wr_req_addr;
            wr_data_d = wr_req_data;
        end else if (rd_gnt) begin
            phase_d   = READ;
            last_rd_d = 1'b1;
            rd_addr_d = rd_req_addr;
        end
        if (wr_req_valid && rd_req_valid && conflict_q != 16'hFFFF)
            conflict_d = conflict_q + 16'd1;
    end

    // Token enters on the edge that samples ram_read; RAM data is valid one stage before the output.
    always_comb begin
        vld_pipe_d = {vld_pipe_q[RD_LATENCY-1:0], phase_q == READ};
        rsp_data_d = vld_pipe_q[RD_LATENCY-1] ? ram_data_out : rsp_data_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            phase_q    <= IDLE;
            last_rd_q  <= 1'b1;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_addr_q  <= '0;
            vld_pipe_q <= '0;
            rsp_data_q <= '0;
            conflict_q <= '0;
        end else begin
            phase_q    <= phase_d;
            last_rd_q  <= last_rd_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_addr_q  <= rd_addr_d;
            vld_pipe_q <= vld_pipe_d;
            rsp_data_q <= rsp_data_d;
            conflict_q <= conflict_d;
        end
    end

    always_comb begin
        wr_req_ready   = wr_gnt;
        rd_req_ready   = rd_gnt;
        ram_write      = (phase_q == WRITE);
        ram_read       = (phase_q == READ);
        ram_wr_address = wr_addr_q;
        ram_data_in    = wr_data_q;
        ram_rd_address = rd_addr_q;
        rd_rsp_valid   = vld_pipe_q[RD_LATENCY];
        rd_rsp_data    = rsp_data_q;
        conflict_count = conflict_q;
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: two instances (read latency 1 and 3) share one stimulus and are
// checked every cycle against a transaction-level model, plus directed literal checks.
`timescale 1ns/1ps
module tb_ram_access_arbiter;

    localparam int L0 = 1;
    localparam int L1 = 3;

    logic        clock;
    logic        resetn;
    logic        wv, rv;
    logic [11:0] wa, ra;
    logic [63:0] wd;

    logic [1:0]  wr_rdy, rd_rdy, rsp_v, ram_w, ram_r;
    logic [63:0] rsp_d [2];
    logic [11:0] ram_wa [2];
    logic [63:0] ram_wd [2];
    logic [11:0] ram_ra [2];
    logic [63:0] rdo [2];
    logic [15:0] cnt [2];

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;
    bit zero_mem = 1;

    ram_access_arbiter #(.DATA_W(64), .ADDR_W(12), .RD_LATENCY(L0)) u0 (
        .clock(clock), .resetn(resetn),
        .wr_req_valid(wv), .wr_req_ready(wr_rdy[0]), .wr_req_addr(wa), .wr_req_data(wd),
        .rd_req_valid(rv), .rd_req_ready(rd_rdy[0]), .rd_req_addr(ra),
        .rd_rsp_valid(rsp_v[0]), .rd_rsp_data(rsp_d[0]),
        .ram_write(ram_w[0]), .ram_wr_address(ram_wa[0]), .ram_data_in(ram_wd[0]),
        .ram_read(ram_r[0]), .ram_rd_address(ram_ra[0]), .ram_data_out(rdo[0]),
        .conflict_count(cnt[0]));

    ram_access_arbiter #(.DATA_W(64), .ADDR_W(12), .RD_LATENCY(L1)) u1 (
        .clock(clock), .resetn(resetn),
        .wr_req_valid(wv), .wr_req_ready(wr_rdy[1]), .wr_req_addr(wa), .wr_req_data(wd),
        .rd_req_valid(rv), .rd_req_ready(rd_rdy[1]), .rd_req_addr(ra),
        .rd_rsp_valid(rsp_v[1]), .rd_rsp_data(rsp_d[1]),
        .ram_write(ram_w[1]), .ram_wr_address(ram_wa[1]), .ram_data_in(ram_wd[1]),
        .ram_read(ram_r[1]), .ram_rd_address(ram_ra[1]), .ram_data_out(rdo[1]),
        .conflict_count(cnt[1]));

    initial clock = 0;
    always #5 clock = ~clock;

    // RAM behind each instance: read data appears RD_LATENCY edges after the sampling edge.
    logic [63:0] mem [2][4096];
    logic [63:0] dly [2][4];
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (zero_mem) begin
                for (int a = 0; a < 4096; a++) mem[i][a] <= '0;
            end else if (ram_w[i]) begin
                mem[i][ram_wa[i]] <= ram_wd[i];
            end
            dly[i][0] <= mem[i][ram_ra[i]];
            for (int k = 1; k < 4; k++) dly[i][k] <= dly[i][k-1];
        end
    end
    assign rdo[0] = dly[0][L0-1];
    assign rdo[1] = dly[1][L1-1];

    // Transaction-level model: who wins, what the RAM side shows next cycle, and when/what each
    // read response must be (response slots indexed by cycle number).
    logic [63:0] mmem [4096];
    bit          m_last_rd;
    bit          m_w, m_r;
    logic [11:0] m_wa, m_ra;
    logic [63:0] m_wd;
    logic [15:0] m_cnt;
    bit          sv [2][16];
    logic [63:0] sd [2][16];
    int          cyc = 0;

    always @(posedge clock or negedge resetn) begin
        bit aw, ar;
        if (!resetn) begin
            if (zero_mem) for (int a = 0; a < 4096; a++) mmem[a] = '0;
            m_last_rd = 1; m_w = 0; m_r = 0;
            m_wa = '0; m_wd = '0; m_ra = '0; m_cnt = '0;
            for (int i = 0; i < 2; i++) for (int s = 0; s < 16; s++) begin sv[i][s] = 0; sd[i][s] = '0; end
        end else begin
            if (m_w) mmem[m_wa] = m_wd;
            sv[0][cyc % 16] = 0;
            sv[1][cyc % 16] = 0;
            cyc++;
            aw = wv && (!rv || m_last_rd);
            ar = rv && !aw;
            if (wv && rv && m_cnt != 16'hFFFF) m_cnt++;
            m_w = aw;
            m_r = ar;
            if (aw) begin m_wa = wa; m_wd = wd; m_last_rd = 0; end
            if (ar) begin
                m_ra = ra;
                m_last_rd = 1;
                sv[0][(cyc + 1 + L0) % 16] = 1; sd[0][(cyc + 1 + L0) % 16] = mmem[ra];
                sv[1][(cyc + 1 + L1) % 16] = 1; sd[1][(cyc + 1 + L1) % 16] = mmem[ra];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("wr_ready[%0d]", i), 64'(wr_rdy[i]), 64'(resetn && wv && (!rv || m_last_rd)));
                chk($sformatf("rd_ready[%0d]", i), 64'(rd_rdy[i]), 64'(resetn && rv && (!wv || !m_last_rd)));
                chk($sformatf("ram_write[%0d]", i), 64'(ram_w[i]), 64'(m_w));
                chk($sformatf("ram_read[%0d]", i), 64'(ram_r[i]), 64'(m_r));
                chk($sformatf("ram_wr_address[%0d]", i), 64'(ram_wa[i]), 64'(m_wa));
                chk($sformatf("ram_data_in[%0d]", i), ram_wd[i], m_wd);
                chk($sformatf("ram_rd_address[%0d]", i), 64'(ram_ra[i]), 64'(m_ra));
                chk($sformatf("rd_rsp_valid[%0d]", i), 64'(rsp_v[i]), 64'(sv[i][cyc % 16]));
                if (sv[i][cyc % 16]) chk($sformatf("rd_rsp_data[%0d]", i), rsp_d[i], sd[i][cyc % 16]);
                chk($sformatf("conflict_count[%0d]", i), 64'(cnt[i]), 64'(m_cnt));
                chk($sformatf("strobe_excl[%0d]", i), 64'(ram_w[i] && ram_r[i]), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [11:0] rnd_addr();
        if ($urandom_range(3, 0) == 0) return 12'($urandom);
        return 12'($urandom_range(15, 0));
    endfunction

    initial begin
        logic [63:0] vals [4];
        int n;
        bit wacc, racc;
        vals[0] = 64'h1111_0000_AAAA_0000;
        vals[1] = 64'h2222_0000_BBBB_0001;
        vals[2] = 64'h3333_0000_CCCC_0002;
        vals[3] = 64'h4444_0000_DDDD_0003;

        // reset held with both requesters pending
        resetn = 0; wv = 1; rv = 1; wa = 12'h200; wd = 64'h0123_4567_89AB_CDEF; ra = 12'h201;
        chk_en = 1;
        repeat (3) tick();
        zero_mem = 0;
        @(negedge clock);
        chk("rst_wr_ready", 64'(wr_rdy[0]), 0);
        chk("rst_rd_ready", 64'(rd_rdy[1]), 0);
        chk("rst_strobes", 64'({ram_w, ram_r}), 0);
        chk("rst_rsp_valid", 64'(rsp_v), 0);
        chk("rst_rsp_data", rsp_d[1], 0);
        chk("rst_wr_address", 64'(ram_wa[0]), 0);
        chk("rst_conflict", 64'(cnt[0]), 0);
        tick();
        resetn = 1;

        // continuous collision: writer first, then strict alternation
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            chk($sformatf("alt_wr_grant%0d", k), 64'(wr_rdy[0]), 64'(k % 2 == 0));
            chk($sformatf("alt_rd_grant%0d", k), 64'(rd_rdy[1]), 64'(k % 2 == 1));
            tick();
        end
        wv = 0; rv = 0;
        @(negedge clock);
        chk("conflict_8_l1", 64'(cnt[0]), 8);
        chk("conflict_8_l3", 64'(cnt[1]), 8);
        repeat (2) tick();

        // single write
        wv = 1; wa = 12'h0A5; wd = 64'hDEADBEEF_CAFEF00D;
        @(negedge clock);
        chk("w1_ready", 64'(wr_rdy[0]), 1);
        tick();
        wv = 0;
        @(negedge clock);
        chk("w1_ram_write", 64'(ram_w[0]), 1);
        chk("w1_ram_addr", 64'(ram_wa[0]), 64'h0A5);
        chk("w1_ram_data", ram_wd[0], 64'hDEADBEEF_CAFEF00D);
        chk("w1_ram_read", 64'(ram_r[0]), 0);
        tick();

        // write then read the top address
        wv = 1; wa = 12'hFFF; wd = 64'h1234;
        tick();
        wv = 0; rv = 1; ra = 12'hFFF;
        @(negedge clock);
        chk("raw_rd_ready", 64'(rd_rdy[0]), 1);
        tick();
        rv = 0;
        @(negedge clock);
        chk("raw_ram_read", 64'(ram_r[0]), 1);
        chk("raw_ram_rd_addr", 64'(ram_ra[0]), 64'hFFF);
        tick();
        @(negedge clock);
        chk("raw_rsp_early", 64'(rsp_v[0]), 0);
        tick();
        @(negedge clock);
        chk("raw_rsp_valid_l1", 64'(rsp_v[0]), 1);
        chk("raw_rsp_data_l1", rsp_d[0], 64'h1234);
        tick();
        @(negedge clock);
        chk("raw_rsp_pulse_l1", 64'(rsp_v[0]), 0);
        chk("raw_rsp_early_l3", 64'(rsp_v[1]), 0);
        tick();
        @(negedge clock);
        chk("raw_rsp_valid_l3", 64'(rsp_v[1]), 1);
        chk("raw_rsp_data_l3", rsp_d[1], 64'h1234);
        tick();

        // four back-to-back reads, latency 3
        for (int k = 0; k < 4; k++) begin
            wv = 1; wa = 12'(k); wd = vals[k];
            tick();
        end
        wv = 0;
        for (int k = 0; k < 4; k++) begin
            rv = 1; ra = 12'(k);
            tick();
        end
        rv = 0;
        @(negedge clock);
        chk("b2b_rsp_early", 64'(rsp_v[1]), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clock);
            chk($sformatf("b2b_rsp_valid%0d", k), 64'(rsp_v[1]), 1);
            chk($sformatf("b2b_rsp_data%0d", k), rsp_d[1], vals[k]);
        end
        repeat (4) tick();

        // reset right after a read is accepted drops its response
        rv = 1; ra = 12'h003;
        @(negedge clock);
        chk("rr_rd_ready", 64'(rd_rdy[0]), 1);
        tick();
        rv = 0;
        resetn = 0;
        @(negedge clock);
        chk("rr_conflict_l1", 64'(cnt[0]), 0);
        chk("rr_conflict_l3", 64'(cnt[1]), 0);
        repeat (2) tick();
        resetn = 1;
        n = 0;
        repeat (12) begin
            @(negedge clock);
            if (rsp_v != 2'b00) n++;
            tick();
        end
        chk("rr_no_rsp", 64'(n), 0);

        // randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            resetn = !(c % 500 == 250 || c % 500 == 251);
            if (!wv && $urandom_range(1, 0) == 1) begin wv = 1; wa = rnd_addr(); wd = {$urandom, $urandom}; end
            if (!rv && $urandom_range(1, 0) == 1) begin rv = 1; ra = rnd_addr(); end
            @(negedge clock);
            wacc = wv && wr_rdy[0];
            racc = rv && rd_rdy[0];
            tick();
            if (wacc) wv = 0;
            if (racc) rv = 0;
        end
        wv = 0; rv = 0;
        repeat (8) tick();
        chk_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
